otter_mcu_sequencer: RTL and testbench
======================================

# otter_mcu_sequencer

Multicycle control sequencer for the OTTER RV32I core. Decides each cycle which datapath resources are active: instruction fetch, IR load, immediate-type select for the immediate generator, PC source, register-file write and data-memory access. It also handles memory wait states, retirement and interrupt/illegal-instruction traps. It sits between the IR/branch-condition logic and the PC mux, register file, memory and immediate select.

## Interface
Parameters:
- `TRAP_ON_ILLEGAL`, 1: when 1, an unrecognised opcode enters TRAP; when 0, it retires as a NOP.

Ports:
- `CLK`  in  1  rising-edge clock
- `RST_N`  in  1  asynchronous, active-low reset
- `IR`  in  32  instruction register contents. Only [6:0] opcode and [14:12] funct3 are used.
- `BR_EQ`, `BR_LT`, `BR_LTU`  in  1 each  branch comparator results for rs1/rs2
- `MEM_RDY`  in  1  memory accepted/completed the current request (either port)
- `INTR`  in  1  level interrupt request
- `MIE`  in  1  interrupt enable (from CSR)
- `MEM_RDEN1`  out  1  instruction read request
- `MEM_RDEN2`  out  1  data read request
- `MEM_WE2`  out  1  data write request
- `IR_LD`  out  1  load IR from memory port 1
- `IMM_SEL`  out  3  immediate type select (package encoding)
- `PC_SOURCE`  out  3  PC mux select (package encoding)
- `PC_WRITE`  out  1  update PC
- `REG_WRITE`  out  1  register-file write enable
- `CSR_TRAP`  out  1  save mepc/mcause, clear MIE
- `TRAP_CAUSE`  out  1  0 = interrupt, 1 = illegal instruction
- `STATE`  out  3  current state, for debug

## Operation
- States: `FETCH`, `DECODE`, `EXEC`, `MEM_WAIT`, `WB`, `TRAP`. Reset state is `FETCH`.
- `FETCH`:
  - `MEM_RDEN1`=1, held until `MEM_RDY`.
  - In the `MEM_RDY` cycle: `IR_LD`=1, next state `DECODE`.
- `DECODE`:
  - Registers `IMM_SEL` from the opcode: OP_IMM/LOAD/JALR→I, STORE→S, BRANCH→B, LUI/AUIPC→U, JAL→J, OP→I (don't-care).
  - Next state is `EXEC`, or `TRAP` if the opcode is illegal and `TRAP_ON_ILLEGAL`=1.
- `EXEC`:
  - OP/OP_IMM/LUI/AUIPC: `REG_WRITE`=1, `PC_WRITE`=1, `PC_SOURCE`=PC4.
  - JAL: `REG_WRITE`=1, `PC_WRITE`=1, `PC_SOURCE`=JAL.
  - JALR: `REG_WRITE`=1, `PC_WRITE`=1, `PC_SOURCE`=JALR.
  - BRANCH: `PC_WRITE`=1. `PC_SOURCE`=BRANCH if taken, else PC4.
    - Taken per funct3: BEQ EQ; BNE !EQ; BLT LT; BGE !LT; BLTU LTU; BGEU !LTU.
    - funct3 010/011 is treated as illegal.
  - LOAD: `MEM_RDEN2`=1, go to `MEM_WAIT`.
  - STORE: `MEM_WE2`=1, go to `MEM_WAIT`.
- `MEM_WAIT`:
  - Holds `MEM_RDEN2`/`MEM_WE2` asserted until `MEM_RDY`.
  - LOAD goes to `WB`.
  - STORE retires in the `MEM_RDY` cycle (`PC_WRITE`=1, PC4).
- `WB`: `REG_WRITE`=1, `PC_WRITE`=1, PC4, then retire.
- Retire cycle (any cycle with `PC_WRITE`=1 outside `TRAP`): next state is `TRAP` if `INTR`&&`MIE`, else `FETCH`.
- `TRAP`:
  - `CSR_TRAP`=1, `PC_WRITE`=1, `PC_SOURCE`=MTVEC.
  - `TRAP_CAUSE` is registered on entry.
  - Next state `FETCH`. Interrupts are not sampled here.
- All outputs except `IMM_SEL`, `TRAP_CAUSE` and `STATE` are Moore/Mealy combinational decodes of state plus registered IR fields. At most one of `MEM_RDEN1`/`MEM_RDEN2`/`MEM_WE2` is high in any cycle.

## Timing
- Reset (async assert, sync release):
  - State=`FETCH`, `IMM_SEL`=I, `TRAP_CAUSE`=0.
  - While `RST_N`=0 all strobes are 0 and `PC_SOURCE`=PC4.
  - `MEM_RDEN1` rises in the first cycle after release.
- Minimum latency with `MEM_RDY` tied 1:
  - ALU/branch/jump/store: 3 cycles (FETCH, DECODE, EXEC; store is +1 for MEM_WAIT).
  - Load: 5 cycles.
- `MEM_RDY` low extends `FETCH`/`MEM_WAIT` indefinitely. Request signals stay stable while waiting.
- `MEM_RDY` asserted outside `FETCH`/`MEM_WAIT` is ignored.
- `INTR` rising in a non-retire cycle is not lost if still high at retire. `INTR` pulsing high only between retires is dropped (level semantics).
- `INTR` in the same cycle as an illegal opcode in `DECODE`: the illegal trap wins, `TRAP_CAUSE`=1.
- Reset mid-`MEM_WAIT` abandons the request immediately; no strobe is asserted during reset.

## Structure
- Package `otter_pkg` holds:
  - `state_t` enum.
  - `imm_sel_t`: I=0, S=1, B=2, U=3, J=4.
  - `pc_src_t`: PC4=0, JALR=1, BRANCH=2, JAL=3, MTVEC=4.
  - `opcode_t` constants (LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP_IMM 0010011, OP 0110011).
- One sub-module, `otter_branch_eval`: combinational taken/illegal evaluation from funct3 and the comparator flags.

## Test plan
- Reset release, `IR`=0x00500093 (addi), `MEM_RDY`=1 → FETCH→DECODE→EXEC. `IMM_SEL`=I. `REG_WRITE`=`PC_WRITE`=1 in cycle 3, `PC_SOURCE`=0.
- `IR`=0x00208463 (beq): with `BR_EQ`=1 → `PC_SOURCE`=2 and `IMM_SEL`=B. With `BR_EQ`=0 → `PC_SOURCE`=0.
- `IR`=0x0000A103 (lw), `MEM_RDY` low 3 cycles in `MEM_WAIT` → `MEM_RDEN2` held 4 cycles, then `WB` with `REG_WRITE`=1. Total 8 cycles.
- `IR`=0x00112023 (sw), `INTR`=`MIE`=1 from DECODE on → `MEM_WE2` until `MEM_RDY`, retire, then `TRAP` with `CSR_TRAP`=1, `PC_SOURCE`=4, `TRAP_CAUSE`=0.
- `IR`=0x0000007F (illegal), `INTR`=1 → `TRAP` right after `DECODE`, `TRAP_CAUSE`=1. With `TRAP_ON_ILLEGAL`=0 → retires as PC4.
- `RST_N` dropped during `MEM_WAIT` (sw, `MEM_RDY`=0) → `MEM_WE2` falls asynchronously, state=`FETCH`, `IMM_SEL`=I.

Source files
------------

// File: rtl/otter_pkg.sv
// Shared encodings for the OTTER multicycle sequencer: states, immediate and
// PC-source selects, RV32I opcodes and branch funct3 codes.
package otter_pkg;

  typedef enum logic [2:0] {
    FETCH    = 3'd0,
    DECODE   = 3'd1,
    EXEC     = 3'd2,
    MEM_WAIT = 3'd3,
    WB       = 3'd4,
    TRAP     = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_sel_t;

  typedef enum logic [2:0] {
    PC_PC4    = 3'd0,
    PC_JALR   = 3'd1,
    PC_BRANCH = 3'd2,
    PC_JAL    = 3'd3,
    PC_MTVEC  = 3'd4
  } pc_src_t;

  typedef logic [6:0] opcode_t;

  localparam opcode_t OPC_LUI    = 7'b0110111;
  localparam opcode_t OPC_AUIPC  = 7'b0010111;
  localparam opcode_t OPC_JAL    = 7'b1101111;
  localparam opcode_t OPC_JALR   = 7'b1100111;
  localparam opcode_t OPC_BRANCH = 7'b1100011;
  localparam opcode_t OPC_LOAD   = 7'b0000011;
  localparam opcode_t OPC_STORE  = 7'b0100011;
  localparam opcode_t OPC_OP_IMM = 7'b0010011;
  localparam opcode_t OPC_OP     = 7'b0110011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  function automatic logic opcode_legal(input opcode_t op);
    case (op)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
      OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP: return 1'b1;
      default:                                 return 1'b0;
    endcase
  endfunction

  // OP has no immediate; I is returned so the select never floats.
  function automatic imm_sel_t imm_sel_of(input opcode_t op);
    case (op)
      OPC_STORE:            return IMM_S;
      OPC_BRANCH:           return IMM_B;
      OPC_LUI, OPC_AUIPC:   return IMM_U;
      OPC_JAL:              return IMM_J;
      default:              return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/otter_branch_eval.sv
// Branch resolution: taken/illegal from funct3 and the rs1/rs2 comparator flags.
// Purely combinational; the reserved funct3 codes 010/011 flag illegal.
module otter_branch_eval
  import otter_pkg::*;
(
  input  logic [2:0] funct3_i,
  input  logic       br_eq_i,
  input  logic       br_lt_i,
  input  logic       br_ltu_i,
  output logic       taken_o,
  output logic       illegal_o
);

  always_comb begin
    taken_o   = 1'b0;
    illegal_o = 1'b0;
    case (funct3_i)
      F3_BEQ:  taken_o = br_eq_i;
      F3_BNE:  taken_o = !br_eq_i;
      F3_BLT:  taken_o = br_lt_i;
      F3_BGE:  taken_o = !br_lt_i;
      F3_BLTU: taken_o = br_ltu_i;
      F3_BGEU: taken_o = !br_ltu_i;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/otter_mcu_sequencer.sv
// Multicycle control FSM for the OTTER RV32I core: fetch/decode/execute,
// memory wait states, retirement and interrupt/illegal-instruction traps.
module otter_mcu_sequencer
  import otter_pkg::*;
#(
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [31:0] IR,
  input  logic        BR_EQ,
  input  logic        BR_LT,
  input  logic        BR_LTU,
  input  logic        MEM_RDY,
  input  logic        INTR,
  input  logic        MIE,
  output logic        MEM_RDEN1,
  output logic        MEM_RDEN2,
  output logic        MEM_WE2,
  output logic        IR_LD,
  output logic [2:0]  IMM_SEL,
  output logic [2:0]  PC_SOURCE,
  output logic        PC_WRITE,
  output logic        REG_WRITE,
  output logic        CSR_TRAP,
  output logic        TRAP_CAUSE,
  output logic [2:0]  STATE
);

  state_t   state_q, state_d;
  imm_sel_t imm_sel_q, imm_sel_d;
  logic     trap_cause_q, trap_cause_d;

  opcode_t  opcode;
  logic     is_load, is_store, is_branch, is_jal, is_jalr, is_alu;
  logic     br_taken, br_illegal, illegal, retire;
  pc_src_t  pc_src;
  logic     unused_ir;

  assign opcode    = IR[6:0];
  assign unused_ir = ^{IR[31:15], IR[11:7]};

  assign is_load   = (opcode == OPC_LOAD);
  assign is_store  = (opcode == OPC_STORE);
  assign is_branch = (opcode == OPC_BRANCH);
  assign is_jal    = (opcode == OPC_JAL);
  assign is_jalr   = (opcode == OPC_JALR);
  assign is_alu    = (opcode == OPC_OP) || (opcode == OPC_OP_IMM) ||
                     (opcode == OPC_LUI) || (opcode == OPC_AUIPC);

  otter_branch_eval u_branch_eval (
    .funct3_i  (IR[14:12]),
    .br_eq_i   (BR_EQ),
    .br_lt_i   (BR_LT),
    .br_ltu_i  (BR_LTU),
    .taken_o   (br_taken),
    .illegal_o (br_illegal)
  );

  assign illegal = !opcode_legal(opcode) || (is_branch && br_illegal);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= FETCH;
      imm_sel_q    <= IMM_I;
      trap_cause_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      imm_sel_q    <= imm_sel_d;
      trap_cause_q <= trap_cause_d;
    end
  end

  // Any PC update outside TRAP retires the instruction; that is the only
  // point at which a pending interrupt is taken.
  assign retire = PC_WRITE && (state_q != TRAP);

  always_comb begin
    state_d      = state_q;
    imm_sel_d    = imm_sel_q;
    trap_cause_d = trap_cause_q;
    case (state_q)
      FETCH:    if (MEM_RDY) state_d = DECODE;
      DECODE: begin
        imm_sel_d = imm_sel_of(opcode);
        if (illegal && TRAP_ON_ILLEGAL) begin
          state_d      = TRAP;
          trap_cause_d = 1'b1;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC:     if (is_load || is_store) state_d = MEM_WAIT;
      MEM_WAIT: if (MEM_RDY && is_load) state_d = WB;
      TRAP:     state_d = FETCH;
      default:  state_d = FETCH;
    endcase
    if (retire) begin
      if (INTR && MIE) begin
        state_d      = TRAP;
        trap_cause_d = 1'b0;
      end else begin
        state_d = FETCH;
      end
    end
  end

  // Strobes are gated by RST_N so nothing is requested while reset is held.
  always_comb begin
    MEM_RDEN1 = 1'b0;
    MEM_RDEN2 = 1'b0;
    MEM_WE2   = 1'b0;
    IR_LD     = 1'b0;
    PC_WRITE  = 1'b0;
    REG_WRITE = 1'b0;
    CSR_TRAP  = 1'b0;
    pc_src    = PC_PC4;
    if (RST_N) begin
      case (state_q)
        FETCH: begin
          MEM_RDEN1 = 1'b1;
          IR_LD     = MEM_RDY;
        end
        EXEC: begin
          if (is_load) begin
            MEM_RDEN2 = 1'b1;
          end else if (is_store) begin
            MEM_WE2 = 1'b1;
          end else begin
            PC_WRITE = 1'b1;
            if (is_jal) begin
              REG_WRITE = 1'b1;
              pc_src    = PC_JAL;
            end else if (is_jalr) begin
              REG_WRITE = 1'b1;
              pc_src    = PC_JALR;
            end else if (is_branch) begin
              pc_src = br_taken ? PC_BRANCH : PC_PC4;
            end else if (is_alu) begin
              REG_WRITE = 1'b1;
            end
          end
        end
        MEM_WAIT: begin
          MEM_RDEN2 = is_load;
          MEM_WE2   = is_store;
          PC_WRITE  = is_store && MEM_RDY;
        end
        WB: begin
          REG_WRITE = 1'b1;
          PC_WRITE  = 1'b1;
        end
        TRAP: begin
          CSR_TRAP = 1'b1;
          PC_WRITE = 1'b1;
          pc_src   = PC_MTVEC;
        end
        default: ;
      endcase
    end
  end

  assign PC_SOURCE  = pc_src;
  assign IMM_SEL    = imm_sel_q;
  assign TRAP_CAUSE = trap_cause_q;
  assign STATE      = state_q;

  assert property (@(posedge CLK) disable iff (!RST_N)
                   $onehot0({MEM_RDEN1, MEM_RDEN2, MEM_WE2}));

endmodule

// File: tb/tb_otter_mcu_sequencer.sv
// Self-checking bench: per-cycle expected traces built from the instruction's
// class, wait counts and interrupt levels, compared against two DUT variants.
module tb_otter_mcu_sequencer;
  import otter_pkg::*;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [31:0] IR;
  logic        BR_EQ, BR_LT, BR_LTU, MEM_RDY, INTR, MIE;
  logic        MEM_RDEN1, MEM_RDEN2, MEM_WE2, IR_LD, PC_WRITE, REG_WRITE, CSR_TRAP, TRAP_CAUSE;
  logic [2:0]  IMM_SEL, PC_SOURCE, STATE;
  logic        n_RDEN1, n_RDEN2, n_WE2, n_IR_LD, n_PC_WRITE, n_REG_WRITE, n_CSR_TRAP, n_TRAP_CAUSE;
  logic [2:0]  n_IMM_SEL, n_PC_SOURCE, n_STATE;

  otter_mcu_sequencer #(.TRAP_ON_ILLEGAL(1'b1)) dut (
    .CLK(CLK), .RST_N(RST_N), .IR(IR), .BR_EQ(BR_EQ), .BR_LT(BR_LT), .BR_LTU(BR_LTU),
    .MEM_RDY(MEM_RDY), .INTR(INTR), .MIE(MIE),
    .MEM_RDEN1(MEM_RDEN1), .MEM_RDEN2(MEM_RDEN2), .MEM_WE2(MEM_WE2), .IR_LD(IR_LD),
    .IMM_SEL(IMM_SEL), .PC_SOURCE(PC_SOURCE), .PC_WRITE(PC_WRITE), .REG_WRITE(REG_WRITE),
    .CSR_TRAP(CSR_TRAP), .TRAP_CAUSE(TRAP_CAUSE), .STATE(STATE)
  );

  otter_mcu_sequencer #(.TRAP_ON_ILLEGAL(1'b0)) dut_nop (
    .CLK(CLK), .RST_N(RST_N), .IR(IR), .BR_EQ(BR_EQ), .BR_LT(BR_LT), .BR_LTU(BR_LTU),
    .MEM_RDY(MEM_RDY), .INTR(INTR), .MIE(MIE),
    .MEM_RDEN1(n_RDEN1), .MEM_RDEN2(n_RDEN2), .MEM_WE2(n_WE2), .IR_LD(n_IR_LD),
    .IMM_SEL(n_IMM_SEL), .PC_SOURCE(n_PC_SOURCE), .PC_WRITE(n_PC_WRITE), .REG_WRITE(n_REG_WRITE),
    .CSR_TRAP(n_CSR_TRAP), .TRAP_CAUSE(n_TRAP_CAUSE), .STATE(n_STATE)
  );

  always #5 CLK = ~CLK;

  localparam logic [31:0] I_ADDI  = 32'h00500093;
  localparam logic [31:0] I_ADD   = 32'h002081B3;
  localparam logic [31:0] I_LUI   = 32'h12345037;
  localparam logic [31:0] I_AUIPC = 32'h00001097;
  localparam logic [31:0] I_JAL   = 32'h008000EF;
  localparam logic [31:0] I_JALR  = 32'h000080E7;
  localparam logic [31:0] I_BEQ   = 32'h00208463;
  localparam logic [31:0] I_LW    = 32'h0000A103;
  localparam logic [31:0] I_SW    = 32'h00112023;
  localparam logic [31:0] I_ILL   = 32'h0000007F;
  localparam logic [31:0] I_ECALL = 32'h00000073;

  // Strobe field order: {rden1, rden2, we2, ir_ld, pc_write, reg_write, csr_trap}
  localparam logic [6:0] S_RD1 = 7'b1000000, S_RD2 = 7'b0100000, S_WE2 = 7'b0010000,
                         S_IRLD = 7'b0001000, S_PCW = 7'b0000100, S_RW = 7'b0000010,
                         S_TRAP = 7'b0000001;

  localparam int K_ALU = 0, K_JAL = 1, K_JALR = 2, K_BR = 3, K_LD = 4, K_ST = 5, K_ILL = 6;

  typedef struct packed {
    logic [2:0] st;
    logic [6:0] strb;
    logic [2:0] pcs;
  } obs_t;

  typedef struct {
    obs_t       o;
    logic       rdy;
    logic       intr;
    logic       chk_imm;
    logic [2:0] imm;
    logic       chk_cause;
    logic       cause;
  } cyc_t;

  cyc_t bq[$];
  cyc_t exp_q[$];
  cyc_t alt_q[$];
  int   checks = 0;
  int   failures = 0;
  int   first_pcw, n_rd2_wait, n_we2_wait, n_cyc;

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic int klass(input logic [31:0] ir);
    logic [2:0] f3;
    f3 = ir[14:12];
    case (ir[6:0])
      7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111: return K_ALU;
      7'b1101111: return K_JAL;
      7'b1100111: return K_JALR;
      7'b1100011: return (f3 == 3'b010 || f3 == 3'b011) ? K_ILL : K_BR;
      7'b0000011: return K_LD;
      7'b0100011: return K_ST;
      default:    return K_ILL;
    endcase
  endfunction

  function automatic logic [2:0] imm_exp(input logic [31:0] ir);
    case (ir[6:0])
      7'b0100011:             return 3'd1;
      7'b1100011:             return 3'd2;
      7'b0110111, 7'b0010111: return 3'd3;
      7'b1101111:             return 3'd4;
      default:                return 3'd0;
    endcase
  endfunction

  function automatic logic taken(input logic [2:0] f3, input logic eq, input logic lt, input logic ltu);
    case (f3)
      3'b000:  return eq;
      3'b001:  return !eq;
      3'b100:  return lt;
      3'b101:  return !lt;
      3'b110:  return ltu;
      3'b111:  return !ltu;
      default: return 1'b0;
    endcase
  endfunction

  function automatic cyc_t cy(input logic [2:0] st, input logic [6:0] strb, input logic [2:0] pcs,
                              input logic rdy, input logic intr);
    cyc_t r;
    r.o = {st, strb, pcs};
    r.rdy = rdy; r.intr = intr;
    r.chk_imm = 1'b0; r.imm = 3'd0; r.chk_cause = 1'b0; r.cause = 1'b0;
    return r;
  endfunction

  // ie: INTR level during fetch/decode; il: INTR level from execute to retire.
  task automatic build(input logic [31:0] ir, input int fw, input int mw, input logic ie,
                       input logic il, input logic mie, input logic eq, input logic lt,
                       input logic ltu, input bit tp);
    int k, dec;
    cyc_t e;
    k = klass(ir);
    bq.delete();
    for (int i = 0; i < fw; i++) bq.push_back(cy(3'd0, S_RD1, 3'd0, 1'b0, ie));
    bq.push_back(cy(3'd0, S_RD1 | S_IRLD, 3'd0, 1'b1, ie));
    bq.push_back(cy(3'd1, 7'd0, 3'd0, rbit(), ie));
    dec = bq.size();
    if (k == K_ILL && tp) begin
      e = cy(3'd5, S_PCW | S_TRAP, 3'd4, rbit(), rbit());
      e.chk_cause = 1'b1; e.cause = 1'b1;
      bq.push_back(e);
      return;
    end
    case (k)
      K_ALU:  bq.push_back(cy(3'd2, S_RW | S_PCW, 3'd0, rbit(), il));
      K_JAL:  bq.push_back(cy(3'd2, S_RW | S_PCW, 3'd3, rbit(), il));
      K_JALR: bq.push_back(cy(3'd2, S_RW | S_PCW, 3'd1, rbit(), il));
      K_BR:   bq.push_back(cy(3'd2, S_PCW, taken(ir[14:12], eq, lt, ltu) ? 3'd2 : 3'd0, rbit(), il));
      K_LD: begin
        bq.push_back(cy(3'd2, S_RD2, 3'd0, rbit(), il));
        for (int i = 0; i < mw; i++) bq.push_back(cy(3'd3, S_RD2, 3'd0, 1'b0, il));
        bq.push_back(cy(3'd3, S_RD2, 3'd0, 1'b1, il));
        bq.push_back(cy(3'd4, S_RW | S_PCW, 3'd0, rbit(), il));
      end
      K_ST: begin
        bq.push_back(cy(3'd2, S_WE2, 3'd0, rbit(), il));
        for (int i = 0; i < mw; i++) bq.push_back(cy(3'd3, S_WE2, 3'd0, 1'b0, il));
        bq.push_back(cy(3'd3, S_WE2 | S_PCW, 3'd0, 1'b1, il));
      end
      default: bq.push_back(cy(3'd2, S_PCW, 3'd0, rbit(), il));
    endcase
    if (k != K_ILL)
      for (int i = dec; i < bq.size(); i++) begin
        bq[i].chk_imm = 1'b1;
        bq[i].imm = imm_exp(ir);
      end
    if (il && mie) begin
      e = cy(3'd5, S_PCW | S_TRAP, 3'd4, rbit(), rbit());
      e.chk_cause = 1'b1; e.cause = 1'b0;
      bq.push_back(e);
    end
  endtask

  // Drives exp_q's per-cycle inputs from a negedge and compares outputs 1 time unit later.
  task automatic run_trace(input string name, input logic [31:0] ir, input logic mie,
                           input logic eq, input logic lt, input logic ltu, input bit use_alt);
    obs_t got;
    first_pcw = 0; n_rd2_wait = 0; n_we2_wait = 0; n_cyc = 0;
    IR = ir; MIE = mie; BR_EQ = eq; BR_LT = lt; BR_LTU = ltu;
    for (int i = 0; i < exp_q.size(); i++) begin
      MEM_RDY = exp_q[i].rdy;
      INTR    = exp_q[i].intr;
      #1;
      n_cyc++;
      if (PC_WRITE === 1'b1 && first_pcw == 0) first_pcw = n_cyc;
      if (STATE === 3'd3 && MEM_RDEN2 === 1'b1) n_rd2_wait++;
      if (STATE === 3'd3 && MEM_WE2 === 1'b1) n_we2_wait++;
      got = {STATE, MEM_RDEN1, MEM_RDEN2, MEM_WE2, IR_LD, PC_WRITE, REG_WRITE, CSR_TRAP, PC_SOURCE};
      checks++;
      if (got !== exp_q[i].o) begin
        failures++;
        $display("FAIL %s cyc%0d {state,strobes,pcsrc} got=%h exp=%h", name, i, got, exp_q[i].o);
      end
      if (exp_q[i].chk_imm) begin
        checks++;
        if (IMM_SEL !== exp_q[i].imm) begin
          failures++;
          $display("FAIL %s cyc%0d IMM_SEL got=%0d exp=%0d", name, i, IMM_SEL, exp_q[i].imm);
        end
      end
      if (exp_q[i].chk_cause) begin
        checks++;
        if (TRAP_CAUSE !== exp_q[i].cause) begin
          failures++;
          $display("FAIL %s cyc%0d TRAP_CAUSE got=%0d exp=%0d", name, i, TRAP_CAUSE, exp_q[i].cause);
        end
      end
      if (use_alt && i < alt_q.size()) begin
        got = {n_STATE, n_RDEN1, n_RDEN2, n_WE2, n_IR_LD, n_PC_WRITE, n_REG_WRITE, n_CSR_TRAP, n_PC_SOURCE};
        checks++;
        if (got !== alt_q[i].o) begin
          failures++;
          $display("FAIL %s_nop cyc%0d {state,strobes,pcsrc} got=%h exp=%h", name, i, got, alt_q[i].o);
        end
      end
      @(negedge CLK);
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST_N = 1'b0; MEM_RDY = 1'b0; INTR = 1'b0; MIE = 1'b0;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge CLK);
    RST_N = 1'b0; IR = I_SW; MEM_RDY = 1'b1; INTR = 1'b1; MIE = 1'b1;
    repeat (2) @(negedge CLK);
    #1;
    checks++;
    if ({STATE, MEM_RDEN1, MEM_RDEN2, MEM_WE2, IR_LD, PC_WRITE, REG_WRITE, CSR_TRAP, PC_SOURCE} !== 13'd0) begin
      failures++;
      $display("FAIL reset_outputs got state=%0d rd1=%b pcw=%b pcs=%0d exp all zero", STATE, MEM_RDEN1, PC_WRITE, PC_SOURCE);
    end
    checks++;
    if (IMM_SEL !== 3'd0 || TRAP_CAUSE !== 1'b0) begin
      failures++;
      $display("FAIL reset_regs got imm=%0d cause=%b exp imm=0 cause=0", IMM_SEL, TRAP_CAUSE);
    end
    checks++;
    if (n_RDEN1 !== 1'b0 || n_STATE !== 3'd0) begin
      failures++;
      $display("FAIL reset_nop got rd1=%b state=%0d exp 0/0", n_RDEN1, n_STATE);
    end
    @(negedge CLK);
    RST_N = 1'b1;
    #1;
    checks++;
    if (MEM_RDEN1 !== 1'b1 || STATE !== 3'd0) begin
      failures++;
      $display("FAIL reset_release got rd1=%b state=%0d exp rd1=1 state=0", MEM_RDEN1, STATE);
    end
  endtask

  task automatic test_alu();
    do_reset();
    build(I_ADDI, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    exp_q = bq;
    run_trace("alu_addi", I_ADDI, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (first_pcw !== 3) begin
      failures++;
      $display("FAIL alu_latency got=%0d exp=3", first_pcw);
    end
  endtask

  task automatic test_branch();
    logic [31:0] ir;
    logic [2:0]  f3;
    logic        eq, lt, ltu;
    do_reset();
    build(I_BEQ, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    exp_q = bq;
    run_trace("beq_taken", I_BEQ, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    build(I_BEQ, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    exp_q = bq;
    run_trace("beq_not_taken", I_BEQ, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    checks++;
    if (first_pcw !== 3) begin
      failures++;
      $display("FAIL branch_latency got=%0d exp=3", first_pcw);
    end
    for (int n = 0; n < 12; n++) begin
      f3 = 3'($urandom_range(0, 7));
      if (f3 == 3'b010 || f3 == 3'b011) f3 = 3'b100;
      ir = I_BEQ; ir[14:12] = f3;
      eq = rbit(); lt = rbit(); ltu = rbit();
      build(ir, $urandom_range(0, 2), 0, 1'b0, 1'b0, 1'b0, eq, lt, ltu, 1'b1);
      exp_q = bq;
      run_trace("branch_rand", ir, 1'b0, eq, lt, ltu, 1'b0);
    end
  endtask

  task automatic test_load_wait();
    do_reset();
    build(I_LW, 0, 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    exp_q = bq;
    run_trace("lw_wait3", I_LW, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (first_pcw !== 8 || n_rd2_wait !== 4) begin
      failures++;
      $display("FAIL lw_wait_timing got retire=%0d rd2_wait=%0d exp retire=8 rd2_wait=4", first_pcw, n_rd2_wait);
    end
    build(I_LW, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    exp_q = bq;
    run_trace("lw_nowait", I_LW, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (first_pcw !== 5) begin
      failures++;
      $display("FAIL lw_min_latency got=%0d exp=5", first_pcw);
    end
  endtask

  task automatic test_store_intr();
    do_reset();
    build(I_SW, 0, 2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    exp_q = bq;
    run_trace("sw_intr", I_SW, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (first_pcw !== 6 || n_we2_wait !== 3) begin
      failures++;
      $display("FAIL sw_timing got retire=%0d we2_wait=%0d exp retire=6 we2_wait=3", first_pcw, n_we2_wait);
    end
    #1;
    checks++;
    if (STATE !== 3'd0) begin
      failures++;
      $display("FAIL trap_returns_fetch got state=%0d exp=0", STATE);
    end
  endtask

  task automatic test_illegal();
    do_reset();
    build(I_ILL, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    exp_q = bq;
    build(I_ILL, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    alt_q = bq;
    run_trace("illegal", I_ILL, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (first_pcw !== 3) begin
      failures++;
      $display("FAIL illegal_trap_latency got=%0d exp=3", first_pcw);
    end
    do_reset();
    build(I_ILL, 1, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    exp_q = bq;
    run_trace("illegal_vs_intr", I_ILL, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    build(32'h0000B063, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    exp_q = bq;
    run_trace("branch_f3_011", 32'h0000B063, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_intr_pulse();
    do_reset();
    build(I_ADDI, 1, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    exp_q = bq;
    run_trace("intr_pulse_dropped", I_ADDI, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    INTR = 1'b0;
    #1;
    checks++;
    if (STATE !== 3'd0 || CSR_TRAP !== 1'b0) begin
      failures++;
      $display("FAIL intr_pulse_no_trap got state=%0d csr_trap=%b exp state=0 csr_trap=0", STATE, CSR_TRAP);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] pool [12];
    logic [31:0] ir;
    logic eq, lt, ltu, ie, il, mie;
    pool = '{I_ADDI, I_ADD, I_LUI, I_AUIPC, I_JAL, I_JALR, I_BEQ, I_LW, I_SW, I_ILL, I_ECALL, 32'h0000A063};
    do_reset();
    for (int n = 0; n < 40; n++) begin
      ir = pool[$urandom_range(0, 11)];
      if (ir[6:0] == 7'b1100011) ir[14:12] = 3'($urandom_range(0, 7));
      eq = rbit(); lt = rbit(); ltu = rbit(); ie = rbit(); il = rbit(); mie = rbit();
      build(ir, $urandom_range(0, 2), $urandom_range(0, 2), ie, il, mie, eq, lt, ltu, 1'b1);
      exp_q = bq;
      run_trace("random", ir, mie, eq, lt, ltu, 1'b0);
    end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    IR = I_SW; MIE = 1'b0; INTR = 1'b0; MEM_RDY = 1'b1;
    @(negedge CLK);
    MEM_RDY = 1'b0;
    repeat (2) @(negedge CLK);
    #1;
    checks++;
    if (STATE !== 3'd3 || MEM_WE2 !== 1'b1 || IMM_SEL !== 3'd1) begin
      failures++;
      $display("FAIL sw_in_wait got state=%0d we2=%b imm=%0d exp 3/1/1", STATE, MEM_WE2, IMM_SEL);
    end
    #1;
    RST_N = 1'b0;
    #1;
    checks++;
    if (MEM_WE2 !== 1'b0 || MEM_RDEN1 !== 1'b0 || STATE !== 3'd0 || IMM_SEL !== 3'd0) begin
      failures++;
      $display("FAIL reset_mid_wait got we2=%b rd1=%b state=%0d imm=%0d exp 0/0/0/0", MEM_WE2, MEM_RDEN1, STATE, IMM_SEL);
    end
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  initial begin
    RST_N = 1'b0; IR = 32'd0; BR_EQ = 1'b0; BR_LT = 1'b0; BR_LTU = 1'b0;
    MEM_RDY = 1'b0; INTR = 1'b0; MIE = 1'b0;
    test_reset();
    test_alu();
    test_branch();
    test_load_wait();
    test_store_intr();
    test_illegal();
    test_intr_pulse();
    test_back_to_back();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
